lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-access stage of the RV32I 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its M-stage outputs (opcode, funct3, ALU result, store data).
- Drives a valid/ready data-memory bus with byte enables, then sign- or zero-extends load data for the MEM/WB register.
- Asserts a stall while a memory transaction is outstanding, so the EX/MEM contents stay frozen until the access completes.

Parameters:
- TIMEOUT_CYCLES, 64: cycles spent in REQ+RSP before the access is abandoned; minimum 2.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_opcodeM  in  7  M-stage opcode; 0000011 = load, 0100011 = store
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  in  32  effective byte address
- rdata2M  in  32  store data (rs2)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  32  word address: {ALUResultM[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rsp_valid  in  1  load data valid
- mem_rdata  in  32  raw load word
- rdataM  out  32  extended load result, registered
- stallM  out  1  freeze IF/ID/EX and the EX/MEM register
- misalignM  out  1  misaligned-access pulse
- timeoutM  out  1  bus-timeout pulse

Behaviour:
- memop = load or store opcode. aligned = true for B; addr[0]==0 for H/HU; addr[1:0]==0 for W. Any other funct3 on a memop is treated as W.
- FSM states: IDLE, REQ, RSP, DONE. Reset: state IDLE, counter 0, rdataM 0, misalignM 0, timeoutM 0.
- While rst is high, mem_req_valid and stallM are forced to 0.
- IDLE:
  - memop & aligned: mem_req_valid=1, stallM=1. On ready, a store goes to DONE and a load goes to RSP. Without ready, go to REQ.
  - memop & !aligned: no request, stallM=0, misalignM=1 on the next cycle (single-cycle pulse), rdataM<=0, stay in IDLE.
  - not a memop: all outputs idle, stallM=0.
- REQ: mem_req_valid=1 and stallM=1. The payload is stable because EX/MEM is frozen. On ready, a store goes to DONE and a load goes to RSP.
- RSP: stallM=1. On mem_rsp_valid, rdataM<=extend(mem_rdata) and the state goes to DONE.
- DONE: stallM=0; rdataM is valid this cycle. The next state is always IDLE, and the new instruction is evaluated there.
- Timeout counter:
  - Clears on entering REQ/RSP from IDLE and increments each cycle spent in REQ or RSP.
  - When it reaches TIMEOUT_CYCLES: go to DONE, mem_req_valid drops, rdataM<=0, timeoutM pulses one cycle coincident with DONE.
- mem_rsp_valid seen in IDLE, REQ or DONE is ignored.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = rs2, be = 1111.
- Loads: mem_be=1111 and mem_wdata=0. Selection uses a shift of 8*addr[1:0].
  - LB / LH: sign-extend the selected byte or half.
  - LBU / LHU: zero-extend.
  - LW: whole word.
- rdataM changes only on RSP capture, timeout or misalign; otherwise it holds.
- Latency:
  - Store with ready in IDLE: 1 stall cycle.
  - Load with ready in IDLE and response one cycle later: 2 stall cycles.
  - Each extra wait cycle adds 1.
- Reset mid-transaction: return to IDLE next edge; no pulses; an outstanding response after reset is ignored.

Test Plan:
- SW, addr 0x100, rs2 0xDEADBEEF, ready=1 → one cycle with valid=1, we=1, addr 0x100, be 1111, wdata DEADBEEF, stallM=1; next cycle stallM=0.
- SB, addr 0x103, rs2 0x000000A5 → be 1000, wdata A5A5A5A5. SH, addr 0x102, rs2 0x1234 → be 1100, wdata 12341234.
- LB, addr 0x201, mem_rdata 0x0000F000, ready held low 3 cycles, then response → valid held stable 4 cycles, rdataM=0xFFFFFFF0, stallM low in DONE. Same access as LBU → 0x000000F0.
- LH, addr 0x301 → no request, misalignM pulses 1 cycle, stallM=0, rdataM=0. LW, addr 0x302 → same.
- Load, ready=1, no response for 64 cycles → timeoutM pulse, rdataM=0, stall released, next load proceeds normally.
- rst asserted while in RSP → IDLE, stallM=0, valid=0. A late mem_rsp_valid after reset leaves rdataM unchanged (0).

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Valid/ready data-memory bus between the LSU (master) and data memory (slave).
// The request channel carries byte enables; load data returns on a separate response strobe.
interface lsu_mem_stage_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I memory-access stage: issues loads/stores on the data bus, stalls the pipeline
// while an access is outstanding and extends load data for MEM/WB.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             instr_opcodeM,
  input  logic [2:0]             funct3M,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            rdata2M,
  lsu_mem_stage_if.master        mem,
  output logic [31:0]            rdataM,
  output logic                   stallM,
  output logic                   misalignM,
  output logic                   timeoutM
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  logic        is_load;
  logic        is_store;
  logic        memop;
  logic        is_byte;
  logic        is_half;
  logic        aligned;
  logic [1:0]  offset;
  logic        issue;
  logic        misalign_hit;
  logic        accept;
  logic        rsp_hit;
  logic        in_wait;
  logic        wait_last;
  logic        timeout_hit;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Access decode; funct3 100/101 only mean BU/HU on loads, anything unknown is a word.
  always_comb begin
    is_load  = (instr_opcodeM == OP_LOAD);
    is_store = (instr_opcodeM == OP_STORE);
    memop    = is_load || is_store;
    offset   = ALUResultM[1:0];
    is_byte  = (funct3M == 3'b000) || (is_load && (funct3M == 3'b100));
    is_half  = (funct3M == 3'b001) || (is_load && (funct3M == 3'b101));
    if (is_byte) begin
      aligned = 1'b1;
    end else if (is_half) begin
      aligned = !offset[0];
    end else begin
      aligned = (offset == 2'b00);
    end
  end

  always_comb begin
    shifted = mem.mem_rdata >> {offset, 3'b000};
    case (funct3M)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  // Per-state events; a completing access on the last budget cycle wins over the timeout.
  always_comb begin
    issue        = 1'b0;
    misalign_hit = 1'b0;
    accept       = 1'b0;
    rsp_hit      = 1'b0;
    case (state)
      IDLE: begin
        issue        = memop && aligned;
        misalign_hit = memop && !aligned;
      end
      REQ:     accept  = mem.mem_req_ready;
      RSP:     rsp_hit = mem.mem_rsp_valid;
      default: ;
    endcase
    in_wait     = (state == REQ) || (state == RSP);
    wait_last   = in_wait && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    timeout_hit = wait_last && !rsp_hit && !(accept && is_store);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) begin
          if (mem.mem_req_ready) begin
            state_next = is_store ? DONE : RSP;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (accept) begin
          state_next = is_store ? DONE : RSP;
        end
      end
      RSP: begin
        if (rsp_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next = DONE;
    end
  end

  // Bus payload is only driven while a request is presented; idle bus stays all-zero.
  always_comb begin
    mem.mem_req_valid = 1'b0;
    mem.mem_we        = 1'b0;
    mem.mem_addr      = 32'd0;
    mem.mem_wdata     = 32'd0;
    mem.mem_be        = 4'b0000;
    stallM            = 1'b0;
    if (!rst) begin
      mem.mem_req_valid = issue || (state == REQ);
      stallM            = issue || in_wait;
    end
    if (mem.mem_req_valid) begin
      mem.mem_we   = is_store;
      mem.mem_addr = {ALUResultM[31:2], 2'b00};
      if (!is_store) begin
        mem.mem_be = 4'b1111;
      end else if (is_byte) begin
        mem.mem_wdata = {4{rdata2M[7:0]}};
        mem.mem_be    = 4'b0001 << offset;
      end else if (is_half) begin
        mem.mem_wdata = {2{rdata2M[15:0]}};
        mem.mem_be    = offset[1] ? 4'b1100 : 4'b0011;
      end else begin
        mem.mem_wdata = rdata2M;
        mem.mem_be    = 4'b1111;
      end
    end
  end

  // Timeout budget, load result and the two event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rdataM    <= 32'd0;
      misalignM <= 1'b0;
      timeoutM  <= 1'b0;
    end else begin
      misalignM <= misalign_hit;
      timeoutM  <= timeout_hit;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (in_wait) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rsp_hit) begin
        rdataM <= load_ext;
      end else if (timeout_hit || misalign_hit) begin
        rdataM <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed accesses with a transaction-level model checked
// every cycle, plus literal expectations for the headline cases.
module tb_lsu_mem_stage;

  localparam int         TO       = 64;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  instr_opcodeM = OP_ALU;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] rdata2M = 32'd0;
  logic [31:0] rdataM;
  logic        stallM;
  logic        misalignM;
  logic        timeoutM;

  int checks = 0;
  int passes = 0;

  lsu_mem_stage_if mem ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_opcodeM (instr_opcodeM),
    .funct3M       (funct3M),
    .ALUResultM    (ALUResultM),
    .rdata2M       (rdata2M),
    .mem           (mem),
    .rdataM        (rdataM),
    .stallM        (stallM),
    .misalignM     (misalignM),
    .timeoutM      (timeoutM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2);
    instr_opcodeM = op;
    funct3M       = f3;
    ALUResultM    = addr;
    rdata2M       = rs2;
  endtask

  // Reference rules: access size in bytes, alignment, lanes and load extension.
  function automatic int m_size(input logic [6:0] op, input logic [2:0] f3);
    if (f3 == 3'b000) return 1;
    if (f3 == 3'b001) return 2;
    if (op == OP_LOAD && f3 == 3'b100) return 1;
    if (op == OP_LOAD && f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit m_memop(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic bit m_aligned(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % m_size(op, f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = m_size(op, f3);
    if (op == OP_LOAD || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << int'(addr[1:0]));
    return 4'(3 << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs2);
    int sz;
    sz = m_size(op, f3);
    if (op == OP_LOAD) return 32'd0;
    if (sz == 1) return (rs2 & 32'hFF) * 32'h01010101;
    if (sz == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    w = word >> (8 * int'(addr[1:0]));
    b = w & 32'hFF;
    h = w & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  // Transaction view: an access is in flight, granted or not, with a wait budget;
  // m_finish marks the one released cycle after it ends.
  bit          m_busy    = 1'b0;
  bit          m_granted = 1'b0;
  bit          m_finish  = 1'b0;
  int          m_waited  = 0;
  logic [31:0] m_rdata   = 32'd0;
  bit          m_mis     = 1'b0;
  bit          m_to      = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_granted = 0; m_finish = 0; m_waited = 0;
      m_rdata = 32'd0; m_mis = 0; m_to = 0;
    end else begin
      m_mis = 0;
      m_to  = 0;
      if (m_finish) begin
        m_finish = 0;
      end else if (!m_busy) begin
        if (m_memop(instr_opcodeM) && m_aligned(instr_opcodeM, funct3M, ALUResultM)) begin
          if (mem.mem_req_ready && instr_opcodeM == OP_STORE) begin
            m_finish = 1;
          end else begin
            m_busy    = 1;
            m_granted = mem.mem_req_ready;
            m_waited  = 0;
          end
        end else if (m_memop(instr_opcodeM)) begin
          m_mis   = 1;
          m_rdata = 32'd0;
        end
      end else begin
        m_waited++;
        if (!m_granted && mem.mem_req_ready) begin
          if (instr_opcodeM == OP_STORE) m_finish = 1;
          else m_granted = 1;
        end else if (m_granted && mem.mem_rsp_valid) begin
          m_rdata  = m_load(funct3M, ALUResultM, mem.mem_rdata);
          m_finish = 1;
        end
        if (!m_finish && m_waited == TO) begin
          m_finish = 1;
          m_to     = 1;
          m_rdata  = 32'd0;
        end
        if (m_finish) m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit e_issue;
    bit e_valid;
    bit e_stall;
    e_issue = !rst && !m_busy && !m_finish && m_memop(instr_opcodeM)
              && m_aligned(instr_opcodeM, funct3M, ALUResultM);
    e_valid = e_issue || (!rst && m_busy && !m_granted);
    e_stall = e_issue || (!rst && m_busy);
    checkOutput("req_valid", mem.mem_req_valid, e_valid);
    checkOutput("stall", stallM, e_stall);
    checkOutput("rdata", rdataM, m_rdata);
    checkOutput("misalign", misalignM, m_mis);
    checkOutput("timeout", timeoutM, m_to);
    if (e_valid) begin
      checkOutput("we", mem.mem_we, instr_opcodeM == OP_STORE);
      checkOutput("addr", mem.mem_addr, {ALUResultM[31:2], 2'b00});
      checkOutput("be", mem.mem_be, m_be(instr_opcodeM, funct3M, ALUResultM));
      checkOutput("wdata", mem.mem_wdata, m_wdata(instr_opcodeM, funct3M, rdata2M));
    end
  end

  // Drives one access with a simple memory responder; returns at posedge+1 after the
  // first unstalled cycle, with that cycle's rdataM/timeoutM and the first request payload.
  task automatic doAccess(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int ready_wait, input int rsp_wait,
                          input logic [31:0] word, output int stalls, output int vcount,
                          output logic [3:0] be0, output logic [31:0] wdata0,
                          output logic [31:0] rdata_done, output logic to_done);
    int  held;
    int  since;
    bit  granted;
    bit  ended;
    bit  grant_now;
    bit  valid_now;
    applyStimulus(op, f3, addr, rs2);
    stalls = 0; vcount = 0; held = 0; since = 0; granted = 0; ended = 0;
    be0 = 4'h0; wdata0 = 32'd0; rdata_done = 32'd0; to_done = 1'b0;
    for (int cyc = 0; cyc < 200 && !ended; cyc++) begin
      mem.mem_req_ready = (held >= ready_wait);
      mem.mem_rsp_valid = granted && (rsp_wait >= 0) && (since >= rsp_wait);
      mem.mem_rdata     = mem.mem_rsp_valid ? word : 32'h5A5A5A5A;
      @(negedge clk);
      valid_now = mem.mem_req_valid;
      if (valid_now) begin
        if (vcount == 0) begin
          be0    = mem.mem_be;
          wdata0 = mem.mem_wdata;
        end
        vcount++;
      end
      if (stallM) begin
        stalls++;
      end else begin
        ended      = 1;
        rdata_done = rdataM;
        to_done    = timeoutM;
      end
      grant_now = valid_now && mem.mem_req_ready;
      @(posedge clk);
      #1;
      if (granted) since++;
      if (grant_now) begin
        granted = 1;
        since   = 0;
      end else if (valid_now) begin
        held++;
      end
    end
    if (!ended) checkOutput("access_bound", 32'd0, 32'd1);
    applyStimulus(OP_ALU, 3'b000, 32'd0, 32'd0);
    mem.mem_req_ready = 1'b0;
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rdata     = 32'h5A5A5A5A;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          stalls;
    int          vcount;
    logic [3:0]  be0;
    logic [31:0] wdata0;
    logic [31:0] rd;
    logic        to;

    mem.mem_req_ready = 1'b0;
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rdata     = 32'h5A5A5A5A;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stall", stallM, 1'b0);
    checkOutput("reset_valid", mem.mem_req_valid, 1'b0);
    checkOutput("reset_rdata", rdataM, 32'd0);
    checkOutput("reset_pulses", {misalignM, timeoutM}, 2'b00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Stores with ready in the issue cycle.
    doAccess(OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF, 0, -1, 32'd0, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("sw_stalls", stalls, 1);
    checkOutput("sw_be", be0, 4'b1111);
    checkOutput("sw_wdata", wdata0, 32'hDEADBEEF);
    doAccess(OP_STORE, 3'b000, 32'h103, 32'h000000A5, 0, -1, 32'd0, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("sb_be", be0, 4'b1000);
    checkOutput("sb_wdata", wdata0, 32'hA5A5A5A5);
    doAccess(OP_STORE, 3'b001, 32'h102, 32'h00001234, 0, -1, 32'd0, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("sh_be", be0, 4'b1100);
    checkOutput("sh_wdata", wdata0, 32'h12341234);
    doAccess(OP_STORE, 3'b010, 32'h108, 32'h0BADF00D, 2, -1, 32'd0, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("sw_wait_stalls", stalls, 3);

    // Byte loads with three wait cycles on ready.
    doAccess(OP_LOAD, 3'b000, 32'h201, 32'd0, 3, 0, 32'h0000F000, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("lb_valid_cycles", vcount, 4);
    checkOutput("lb_stalls", stalls, 5);
    checkOutput("lb_rdata", rd, 32'hFFFFFFF0);
    doAccess(OP_LOAD, 3'b100, 32'h201, 32'd0, 3, 0, 32'h0000F000, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("lbu_rdata", rd, 32'h000000F0);

    // Misaligned half and word loads.
    doAccess(OP_LOAD, 3'b001, 32'h301, 32'd0, 0, 0, 32'h11111111, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("lh_mis_stalls", stalls, 0);
    checkOutput("lh_mis_valid", vcount, 0);
    @(negedge clk);
    checkOutput("lh_mis_pulse", misalignM, 1'b1);
    checkOutput("lh_mis_rdata", rdataM, 32'd0);
    @(posedge clk);
    #1;
    doAccess(OP_LOAD, 3'b010, 32'h302, 32'd0, 0, 0, 32'h22222222, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("lw_mis_valid", vcount, 0);
    @(negedge clk);
    checkOutput("lw_mis_pulse", misalignM, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("lw_mis_pulse_end", misalignM, 1'b0);
    @(posedge clk);
    #1;

    doAccess(OP_LOAD, 3'b010, 32'h400, 32'd0, 0, 0, 32'h11223344, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("lw_stalls", stalls, 2);
    checkOutput("lw_rdata", rd, 32'h11223344);
    checkOutput("lw_no_timeout", to, 1'b0);

    // No response: the access is abandoned after the wait budget.
    doAccess(OP_LOAD, 3'b010, 32'h404, 32'd0, 0, -1, 32'd0, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("to_stalls", stalls, TO + 1);
    checkOutput("to_pulse", to, 1'b1);
    checkOutput("to_rdata", rd, 32'd0);
    @(negedge clk);
    checkOutput("to_pulse_end", timeoutM, 1'b0);
    @(posedge clk);
    #1;
    doAccess(OP_LOAD, 3'b001, 32'h402, 32'd0, 1, 1, 32'h80010000, stalls, vcount, be0, wdata0, rd, to);
    checkOutput("lh_after_to_stalls", stalls, 4);
    checkOutput("lh_after_to_rdata", rd, 32'hFFFF8001);

    // Reset while waiting for a load response; a late response is dropped.
    applyStimulus(OP_LOAD, 3'b010, 32'h500, 32'd0);
    mem.mem_req_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_issue_stall", stallM, 1'b1);
    @(posedge clk);
    #1;
    mem.mem_req_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_rsp_stall", stallM, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_forced_stall", stallM, 1'b0);
    checkOutput("rst_forced_valid", mem.mem_req_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(OP_ALU, 3'b000, 32'd0, 32'd0);
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rdata     = 32'hCAFEBABE;
    @(negedge clk);
    checkOutput("rst_cleared_rdata", rdataM, 32'd0);
    @(posedge clk);
    #1;
    mem.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("late_rsp_rdata", rdataM, 32'd0);
    checkOutput("late_rsp_stall", stallM, 1'b0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
